// File: rtl/ad7276_pkg.sv
// Shared types and constants for the AD7276 sample-pair to AXI4-Stream packer.
package ad7276_pkg;

    localparam int ADC_LENGTH_DEFAULT = 12;
    localparam int AXIS_WIDTH         = 32;

    typedef struct packed {
        logic [ADC_LENGTH_DEFAULT-1:0] ch1;
        logic [ADC_LENGTH_DEFAULT-1:0] ch0;
    } sample_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } packer_state_t;

    // A programmed frame length of zero behaves as a single-beat frame.
    function automatic logic [15:0] frame_len_eff(input logic [15:0] len);
        if (len == 16'd0) begin
            return 16'd1;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/ad7276_pair_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured sample pairs.
module ad7276_pair_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             full_s;

    // Write into a full FIFO is legal only when a read frees a slot on the same edge.
    always_comb begin
        full_s  = (count_r == (AW+1)'(DEPTH));
        rd_en_s = rd && (count_r != '0);
        wr_en_s = wr && (!full_s || rd_en_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/ad7276_axis_packer.sv
// Packs captured AD7276 channel pairs into 32-bit AXI4-Stream beats with framed TLAST,
// absorbing DMA backpressure and reporting drops and channel misalignment.
module ad7276_axis_packer
    import ad7276_pkg::*;
#(
    parameter int ADC_LENGTH = ADC_LENGTH_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*ADC_LENGTH-1:0] i_data,
    input  logic [1:0]              i_valid,
    input  logic                    i_enable,
    input  logic [15:0]             i_frameLen,
    input  logic                    i_clrStatus,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    o_overflow,
    output logic [15:0]             o_dropCount,
    output logic                    o_alignErr,
    output logic                    o_busy
);

    localparam int PW = 2 * ADC_LENGTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    packer_state_t         state_r;
    packer_state_t         state_next_s;
    logic                  cap_s;
    logic                  align_evt_s;
    logic                  drop_evt_s;
    logic                  wr_s;
    logic                  pop_s;
    logic                  hs_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [PW-1:0]         fifo_rdata_s;
    logic [CW-1:0]         fifo_count_s;
    logic [15:0]           beat_cnt_r;
    logic [15:0]           len_r;
    logic [15:0]           len_eff_s;
    logic                  last_s;
    logic                  tvalid_r;
    logic                  tlast_r;
    logic [AXIS_WIDTH-1:0] tdata_r;
    logic                  overflow_r;
    logic [15:0]           drop_r;
    logic                  align_r;
    logic                  busy_r;

    ad7276_pair_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .wr    (wr_s),
        .wdata (i_data),
        .rd    (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Capture, pop and drop decisions for the current cycle.
    always_comb begin
        cap_s       = (state_r == ST_RUN) && (i_valid == 2'b11);
        align_evt_s = (i_valid == 2'b01) || (i_valid == 2'b10);
        hs_s        = tvalid_r && m_axis_tready;
        pop_s       = !fifo_empty_s && (!tvalid_r || m_axis_tready);
        wr_s        = cap_s && (!fifo_full_s || pop_s);
        drop_evt_s  = cap_s && fifo_full_s && !pop_s;
        // The frame length is sampled when the first beat of a frame is loaded.
        len_eff_s   = (beat_cnt_r == 16'd0) ? frame_len_eff(i_frameLen) : len_r;
        last_s      = (beat_cnt_r == (len_eff_s - 16'd1));
    end

    // Next-state logic for IDLE / RUN / DRAIN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_enable) begin
                    state_next_s = ST_RUN;
                end else if ((fifo_count_s == '0) && !tvalid_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Output beat register; the beat index counts loads, each of which is later handshaken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            tdata_r    <= '0;
            beat_cnt_r <= 16'd0;
            len_r      <= 16'd1;
        end else begin
            if (pop_s) begin
                tvalid_r <= 1'b1;
                tlast_r  <= last_s;
                tdata_r  <= {16'(fifo_rdata_s[PW-1:ADC_LENGTH]), 16'(fifo_rdata_s[ADC_LENGTH-1:0])};
            end else if (hs_s) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
            end
            if ((state_r == ST_IDLE) && (state_next_s == ST_RUN)) begin
                beat_cnt_r <= 16'd0;
            end else if (pop_s) begin
                beat_cnt_r <= last_s ? 16'd0 : (beat_cnt_r + 16'd1);
                if (beat_cnt_r == 16'd0) begin
                    len_r <= len_eff_s;
                end
            end
        end
    end

    // Sticky status; a new event outranks a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_r <= 1'b0;
            drop_r     <= 16'd0;
            align_r    <= 1'b0;
        end else begin
            if (drop_evt_s) begin
                overflow_r <= 1'b1;
                if (i_clrStatus) begin
                    drop_r <= 16'd1;
                end else if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'd1;
                end
            end else if (i_clrStatus) begin
                overflow_r <= 1'b0;
                drop_r     <= 16'd0;
            end
            if (align_evt_s) begin
                align_r <= 1'b1;
            end else if (i_clrStatus) begin
                align_r <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign o_overflow    = overflow_r;
    assign o_dropCount   = drop_r;
    assign o_alignErr    = align_r;
    assign o_busy        = busy_r;

endmodule

// File: tb/tb_ad7276_axis_packer.sv
// Bench for ad7276_axis_packer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_ad7276_axis_packer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [23:0] i_data;
    logic [1:0]  i_valid;
    logic        i_enable;
    logic [15:0] i_frameLen;
    logic        i_clrStatus;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_overflow;
    logic [15:0] o_dropCount;
    logic        o_alignErr;
    logic        o_busy;

    always #5 clk = ~clk;

    ad7276_axis_packer dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_enable      (i_enable),
        .i_frameLen    (i_frameLen),
        .i_clrStatus   (i_clrStatus),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .o_overflow    (o_overflow),
        .o_dropCount   (o_dropCount),
        .o_alignErr    (o_alignErr),
        .o_busy        (o_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: mode 0=idle 1=run 2=drain.
    int          m_mode = 0;
    logic [31:0] m_fifo[$];
    bit          m_ov = 0;
    logic [31:0] m_od = 0;
    bit          m_ol = 0;
    int          m_pos = 0;
    int          m_flen = 1;
    bit          m_ovf = 0;
    int          m_drops = 0;
    bit          m_align = 0;

    logic [31:0] obs_d[$];
    bit          obs_l[$];

    function automatic logic [23:0] pk(input int c1, input int c0);
        return {c1[11:0], c0[11:0]};
    endfunction

    function automatic logic [31:0] bt(input int c1, input int c0);
        return 32'((c1 & 32'hFFF) * 65536 + (c0 & 32'hFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, hs, cap, part;
        int nxt;
        if (i_rst) begin
            m_mode = 0; m_fifo.delete(); m_ov = 0; m_od = 0; m_ol = 0;
            m_pos = 0; m_flen = 1; m_ovf = 0; m_drops = 0; m_align = 0;
            return;
        end
        hs   = m_ov && m_axis_tready;
        pop  = (m_fifo.size() != 0) && (!m_ov || m_axis_tready);
        cap  = (m_mode == 1) && (i_valid == 2'b11);
        part = (i_valid == 2'b01) || (i_valid == 2'b10);
        nxt  = m_mode;
        if (m_mode == 0 && i_enable) begin
            nxt = 1;
            m_pos = 0;
        end else if (m_mode == 1 && !i_enable) begin
            nxt = 2;
        end else if (m_mode == 2) begin
            if (i_enable) nxt = 1;
            else if (m_fifo.size() == 0 && !m_ov) nxt = 0;
        end
        if (pop) begin
            if (m_pos == 0) m_flen = (i_frameLen == 0) ? 1 : int'(i_frameLen);
            m_od  = m_fifo.pop_front();
            m_ol  = (m_pos == m_flen - 1);
            m_pos = m_ol ? 0 : m_pos + 1;
            m_ov  = 1;
        end else if (hs) begin
            m_ov = 0;
        end
        if (i_clrStatus) begin
            m_ovf = 0; m_drops = 0; m_align = 0;
        end
        if (cap) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(bt(int'(i_data[23:12]), int'(i_data[11:0])));
            end else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        if (part) m_align = 1;
        m_mode = nxt;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge i_rst);
            model_step();
        end
    end

    // Per-cycle comparison against the model, plus a log of every handshake.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (i_rst !== 1'b1) begin
                chk("tvalid", 32'(m_axis_tvalid), 32'(m_ov));
                if (m_ov) begin
                    chk("tdata", m_axis_tdata, m_od);
                    chk("tlast", 32'(m_axis_tlast), 32'(m_ol));
                end
                chk("overflow", 32'(o_overflow), 32'(m_ovf));
                chk("dropCount", 32'(o_dropCount), 32'(m_drops));
                chk("alignErr", 32'(o_alignErr), 32'(m_align));
                chk("busy", 32'(o_busy), 32'(m_mode != 0));
                if (m_axis_tvalid && m_axis_tready) begin
                    obs_d.push_back(m_axis_tdata);
                    obs_l.push_back(m_axis_tlast);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic put(input logic [1:0] v, input logic [23:0] d);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid     = 2'b00;
            i_clrStatus = 1'b0;
        end
    endtask

    task automatic pulse_clr(input logic [1:0] v);
        @(negedge clk);
        i_clrStatus = 1'b1;
        i_valid     = v;
        @(negedge clk);
        i_clrStatus = 1'b0;
        i_valid     = 2'b00;
        #1;
    endtask

    task automatic wait_obs(input string name, input int n);
        for (int c = 0; c < 400 && obs_d.size() < n; c++) @(negedge clk);
        idle(3);
        chk(name, obs_d.size(), n);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 400 && o_busy; c++) @(negedge clk);
        #1;
        chk(name, 32'(o_busy), 32'd0);
    endtask

    task automatic chk_beat(input string name, input int i, input logic [31:0] d, input bit l);
        if (i < obs_d.size()) begin
            chk({name, "_data"}, obs_d[i], d);
            chk({name, "_last"}, 32'(obs_l[i]), 32'(l));
        end else begin
            chk({name, "_present"}, obs_d.size(), i + 1);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        i_enable = 1'b0;
        wait_idle("restart_idle");
        @(negedge clk);
        i_enable = 1'b1;
        idle(2);
    endtask

    int r;
    int rdy_pct;

    initial begin
        i_rst = 1'b1; i_data = '0; i_valid = 2'b00; i_enable = 1'b0;
        i_frameLen = 16'd4; i_clrStatus = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_drop", 32'(o_dropCount), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;

        // 1: basic stream, latency and framing
        i_enable = 1'b1; m_axis_tready = 1'b1;
        idle(3);
        obs_d.delete(); obs_l.delete();
        put(2'b11, pk(12'h456, 12'h123));
        @(negedge clk);
        i_valid = 2'b00;
        #1 chk("lat_k1_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        #1 chk("lat_k2_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("lat_k2_tdata", m_axis_tdata, 32'h04560123);
        for (int i = 1; i < 12; i++) put(2'b11, pk(12'h456 + i, 12'h123 + i));
        idle(1);
        wait_obs("t1_beats", 12);
        chk_beat("t1_first", 0, 32'h04560123, 1'b0);
        for (int i = 0; i < 12; i++) chk_beat("t1_beat", i, bt(12'h456 + i, 12'h123 + i), ((i + 1) % 4) == 0);

        // 2: stalled sink, overflow then ordered release
        obs_d.delete(); obs_l.delete();
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) put(2'b11, pk(12'h200 + i, 12'h100 + i));
        idle(2);
        #1;
        chk("t2_drops", 32'(o_dropCount), 32'd3);
        chk("t2_ovf", 32'(o_overflow), 32'd1);
        @(negedge clk);
        m_axis_tready = 1'b1;
        wait_obs("t2_beats", 17);
        for (int i = 0; i < 17; i++) chk_beat("t2_beat", i, bt(12'h200 + i, 12'h100 + i), ((i + 1) % 4) == 0);

        // 4: misaligned valid and status clearing
        obs_d.delete(); obs_l.delete();
        put(2'b01, pk(12'h777, 12'h777));
        idle(5);
        #1;
        chk("t4_no_beat", obs_d.size(), 0);
        chk("t4_align", 32'(o_alignErr), 32'd1);
        pulse_clr(2'b00);
        chk("t4_clr_ovf", 32'(o_overflow), 32'd0);
        chk("t4_clr_drop", 32'(o_dropCount), 32'd0);
        chk("t4_clr_align", 32'(o_alignErr), 32'd0);
        pulse_clr(2'b10);
        chk("t4_event_wins", 32'(o_alignErr), 32'd1);
        pulse_clr(2'b00);
        chk("t4_clr_again", 32'(o_alignErr), 32'd0);

        // 3: capture on a full FIFO coinciding with a pop
        obs_d.delete(); obs_l.delete();
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) put(2'b11, pk(12'h310 + i, 12'h300 + i));
        idle(2);
        #1 chk("t3_fill_drops", 32'(o_dropCount), 32'd0);
        @(negedge clk);
        m_axis_tready = 1'b1;
        i_valid = 2'b11;
        i_data  = pk(12'h3AA, 12'h3BB);
        @(negedge clk);
        i_valid = 2'b00;
        #1;
        chk("t3_drops", 32'(o_dropCount), 32'd0);
        chk("t3_ovf", 32'(o_overflow), 32'd0);
        wait_obs("t3_beats", 18);
        chk_beat("t3_full_pop", 17, bt(12'h3AA, 12'h3BB), ((29 + 17 + 1) % 4) == 0);

        // 5: frame length change mid-frame
        restart();
        obs_d.delete(); obs_l.delete();
        put(2'b11, pk(12'h500, 12'h501));
        idle(1);
        wait_obs("t5_first", 1);
        @(negedge clk);
        i_frameLen = 16'd2;
        for (int i = 1; i < 10; i++) put(2'b11, pk(12'h500 + i, 12'h501 + i));
        idle(1);
        wait_obs("t5_beats", 10);
        for (int i = 0; i < 10; i++) chk_beat("t5_beat", i, bt(12'h500 + i, 12'h501 + i), (i == 3) || (i == 5) || (i == 7) || (i == 9));

        // 6: drain with a partial frame, restart, then reset mid-stream
        @(negedge clk);
        i_frameLen = 16'd4;
        restart();
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 6; i++) put(2'b11, pk(12'h600 + i, 12'h610 + i));
        idle(1);
        wait_obs("t6_six", 6);
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 6; i < 9; i++) put(2'b11, pk(12'h600 + i, 12'h610 + i));
        @(negedge clk);
        i_valid  = 2'b00;
        i_enable = 1'b0;
        idle(2);
        #1 chk("t6_drain_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        m_axis_tready = 1'b1;
        wait_obs("t6_nine", 9);
        wait_idle("t6_idle");
        chk_beat("t6_b7", 6, bt(12'h606, 12'h616), 1'b0);
        chk_beat("t6_b8", 7, bt(12'h607, 12'h617), 1'b1);
        chk_beat("t6_b9", 8, bt(12'h608, 12'h618), 1'b0);
        @(negedge clk);
        i_enable = 1'b1;
        idle(2);
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 4; i++) put(2'b11, pk(12'h700 + i, 12'h710 + i));
        idle(1);
        wait_obs("t6_restart", 4);
        for (int i = 0; i < 4; i++) chk_beat("t6_rs", i, bt(12'h700 + i, 12'h710 + i), i == 3);
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) put(2'b11, pk(12'h720 + i, 12'h730 + i));
        idle(2);
        #1 chk("t6_pending", 32'(m_axis_tvalid), 32'd1);
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        idle(2);
        @(negedge clk);
        i_rst = 1'b0;

        // Randomized traffic checked cycle by cycle against the model.
        rdy_pct = 80;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 15);
            i_valid = (r < 8) ? 2'b11 : (r == 8) ? 2'b01 : (r == 9) ? 2'b10 : 2'b00;
            i_data  = 24'($urandom);
            if (c % 64 == 0) rdy_pct = $urandom_range(5, 100);
            m_axis_tready = ($urandom_range(1, 100) <= rdy_pct);
            i_clrStatus   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) i_enable = ~i_enable;
            if ($urandom_range(0, 299) == 0) i_frameLen = 16'($urandom_range(0, 5));
        end
        @(negedge clk);
        i_enable = 1'b1;
        m_axis_tready = 1'b1;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
